// File: rtl/ascon_permutation_xor.sv
// One Ascon round (p_C, p_S, p_L) with pre/post XOR injection on a registered 320-bit state.
// The controller iterates rounds by feeding the register back through the round each clock.

package ascon_pack;
    localparam int unsigned WORD_W  = 64;
    localparam int unsigned N_WORDS = 5;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned ROUND_W = 4;

    // Word 0 holds S0.
    typedef logic [N_WORDS-1:0][WORD_W-1:0] type_state;
endpackage

module ascon_permutation_xor
    import ascon_pack::*;
(
    input  logic                clock_i,
    input  logic                resetb_i,
    input  logic                enable_i,
    input  logic                input_mode_i,
    input  type_state           permutation_i,
    input  logic [ROUND_W-1:0]  round_i,
    input  logic [1:0]          bypass_xor_begin_i,
    input  logic [1:0]          bypass_xor_end_i,
    input  logic [KEY_W-1:0]    key_i,
    input  logic [DATA_W-1:0]   data_i,
    output type_state           permutation_o
);

    type_state s_mux;
    type_state s_begin;
    type_state s_const;
    type_state s_sbox;
    type_state s_lin;
    type_state s_end;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Bitsliced S-box: each 64-bit word operation covers all 64 columns at once.
    function automatic type_state sbox_layer(input type_state s);
        type_state   o;
        logic [WORD_W-1:0] x0, x1, x2, x3, x4;
        logic [WORD_W-1:0] t0, t1, t2, t3, t4;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2];
        x3 = s[3];
        x4 = s[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        o[0] = x0;
        o[1] = x1;
        o[2] = x2;
        o[3] = x3;
        o[4] = x4;
        return o;
    endfunction

    function automatic type_state linear_layer(input type_state s);
        type_state o;
        o[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
        o[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
        o[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
        o[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
        o[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
        return o;
    endfunction

    // Round input select and data/key injection ahead of the round.
    always_comb begin
        s_mux   = input_mode_i ? permutation_i : permutation_o;
        s_begin = s_mux;
        if (bypass_xor_begin_i[0]) begin
            s_begin[0] = s_mux[0] ^ data_i[DATA_W-1:WORD_W];
            s_begin[1] = s_mux[1] ^ data_i[WORD_W-1:0];
        end
        if (bypass_xor_begin_i[1]) begin
            s_begin[2] = s_mux[2] ^ key_i[KEY_W-1:WORD_W];
            s_begin[3] = s_mux[3] ^ key_i[WORD_W-1:0];
        end
    end

    // Round constant lands only in the low byte of S2.
    always_comb begin
        s_const       = s_begin;
        s_const[2][7:0] = s_begin[2][7:0] ^ {~round_i, round_i};
    end

    always_comb begin
        s_sbox = sbox_layer(s_const);
        s_lin  = linear_layer(s_sbox);
    end

    // Key and domain-separation injection after the round.
    always_comb begin
        s_end = s_lin;
        if (bypass_xor_end_i[0]) begin
            s_end[3] = s_lin[3] ^ key_i[KEY_W-1:WORD_W];
            s_end[4] = s_lin[4] ^ key_i[WORD_W-1:0];
        end
        if (bypass_xor_end_i[1]) begin
            s_end[4][0] = s_end[4][0] ^ 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            permutation_o <= '0;
        end else if (enable_i) begin
            permutation_o <= s_end;
        end
    end

endmodule

// File: tb/tb_ascon_permutation_xor.sv
// Directed bench for ascon_permutation_xor: table of single-round vectors plus
// multi-cycle sequences (12-round init, hold, async reset mid-sequence).

module tb_ascon_permutation_xor;
    import ascon_pack::*;

    logic          clock_i = 1'b0;
    logic          resetb_i = 1'b1;
    logic          enable_i = 1'b0;
    logic          input_mode_i = 1'b0;
    type_state     permutation_i = '0;
    logic [3:0]    round_i = '0;
    logic [1:0]    bypass_xor_begin_i = '0;
    logic [1:0]    bypass_xor_end_i = '0;
    logic [127:0]  key_i = '0;
    logic [127:0]  data_i = '0;
    type_state     permutation_o;

    int total = 0;
    int bad = 0;

    ascon_permutation_xor dut (
        .clock_i            (clock_i),
        .resetb_i           (resetb_i),
        .enable_i           (enable_i),
        .input_mode_i       (input_mode_i),
        .permutation_i      (permutation_i),
        .round_i            (round_i),
        .bypass_xor_begin_i (bypass_xor_begin_i),
        .bypass_xor_end_i   (bypass_xor_end_i),
        .key_i              (key_i),
        .data_i             (data_i),
        .permutation_o      (permutation_o)
    );

    always #5 clock_i = ~clock_i;

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    // Reference model: table-lookup S-box per column, bitwise rotations.
    function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[i] = x[(i + n) % 64];
        return o;
    endfunction

    function automatic type_state m_pl(input type_state s);
        type_state o;
        o[0] = s[0] ^ m_rotr(s[0], 19) ^ m_rotr(s[0], 28);
        o[1] = s[1] ^ m_rotr(s[1], 61) ^ m_rotr(s[1], 39);
        o[2] = s[2] ^ m_rotr(s[2], 1)  ^ m_rotr(s[2], 6);
        o[3] = s[3] ^ m_rotr(s[3], 10) ^ m_rotr(s[3], 17);
        o[4] = s[4] ^ m_rotr(s[4], 7)  ^ m_rotr(s[4], 41);
        return o;
    endfunction

    function automatic type_state m_ps(input type_state s);
        type_state o;
        logic [4:0] v;
        for (int j = 0; j < 64; j++) begin
            v = SBOX[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
            o[0][j] = v[4];
            o[1][j] = v[3];
            o[2][j] = v[2];
            o[3][j] = v[1];
            o[4][j] = v[0];
        end
        return o;
    endfunction

    function automatic type_state m_round(input type_state si, input logic [3:0] r,
                                          input logic [1:0] xb, input logic [1:0] xe,
                                          input logic [127:0] k, input logic [127:0] d);
        type_state s;
        s = si;
        if (xb[0]) begin s[0] ^= d[127:64]; s[1] ^= d[63:0]; end
        if (xb[1]) begin s[2] ^= k[127:64]; s[3] ^= k[63:0]; end
        s[2][7:0] ^= {~r, r};
        s = m_pl(m_ps(s));
        if (xe[0]) begin s[3] ^= k[127:64]; s[4] ^= k[63:0]; end
        if (xe[1]) s[4][0] = ~s[4][0];
        return s;
    endfunction

    task automatic check(input string name, input type_state act, input type_state exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic mode, input logic [3:0] r,
                        input logic [1:0] xb, input logic [1:0] xe);
        enable_i           = en;
        input_mode_i       = mode;
        round_i            = r;
        bypass_xor_begin_i = xb;
        bypass_xor_end_i   = xe;
        @(posedge clock_i);
        #1;
    endtask

    typedef struct {
        string        name;
        logic [3:0]   r;
        logic [1:0]   xb;
        logic [1:0]   xe;
        type_state    s_in;
        type_state    exp;
    } vec_t;

    localparam logic [127:0] KEY  = 128'h691AED630E81901F6CB10AD9CA912F80;
    localparam logic [127:0] DATA = 128'h0123456789ABCDEFFEDCBA9876543210;

    type_state init_state;
    type_state pre_zero;
    type_state exp_init;
    type_state exp_last_noxor;
    type_state exp_r5;
    type_state s_tmp;
    type_state mixed;
    vec_t      vecs [9];

    initial begin
        init_state[0] = 64'h00001000808C0001;
        init_state[1] = 64'h6CB10AD9CA912F80;
        init_state[2] = 64'h691AED630E81901F;
        init_state[3] = 64'h0C4C36A20853217C;
        init_state[4] = 64'h46487B3E06D9D7A8;
        mixed[0] = 64'hDEADBEEF01234567;
        mixed[1] = 64'h0F0F0F0FF0F0F0F0;
        mixed[2] = 64'hAAAAAAAA55555555;
        mixed[3] = 64'h8000000000000001;
        mixed[4] = 64'hFFFFFFFFFFFFFFFF;

        // Zero state, r=0: state entering p_L is known by hand.
        pre_zero[0] = 64'hF0;
        pre_zero[1] = 64'hF0;
        pre_zero[2] = 64'hFFFFFFFFFFFFFF0F;
        pre_zero[3] = 64'hF0;
        pre_zero[4] = 64'h0;

        vecs[0] = '{"zero_r0",     4'd0,  2'b00, 2'b00, '0, m_pl(pre_zero)};
        vecs[1] = '{"xb_data",     4'd0,  2'b01, 2'b00, '0, m_round('0, 4'd0, 2'b01, 2'b00, KEY, DATA)};
        vecs[2] = '{"xb_key",      4'd0,  2'b10, 2'b00, '0, m_round('0, 4'd0, 2'b10, 2'b00, KEY, DATA)};
        vecs[3] = '{"xe_one",      4'd0,  2'b00, 2'b10, '0, m_pl(pre_zero)};
        vecs[3].exp[4][0] = ~vecs[3].exp[4][0];
        vecs[4] = '{"xe_key",      4'd0,  2'b00, 2'b01, '0, m_round('0, 4'd0, 2'b00, 2'b01, KEY, DATA)};
        vecs[5] = '{"all_xor",     4'd0,  2'b11, 2'b11, '0, m_round('0, 4'd0, 2'b11, 2'b11, KEY, DATA)};
        vecs[6] = '{"init_r12",    4'd12, 2'b00, 2'b00, init_state, m_round(init_state, 4'd12, 2'b00, 2'b00, KEY, DATA)};
        vecs[7] = '{"init_r15",    4'd15, 2'b00, 2'b00, init_state, m_round(init_state, 4'd15, 2'b00, 2'b00, KEY, DATA)};
        vecs[8] = '{"mixed_r7",    4'd7,  2'b11, 2'b00, mixed, m_round(mixed, 4'd7, 2'b11, 2'b00, KEY, DATA)};

        s_tmp = init_state;
        for (int r = 0; r < 12; r++) begin
            if (r == 5) exp_r5 = m_round(s_tmp, 4'(r), 2'b00, 2'b00, KEY, 128'h0);
            if (r == 11) exp_last_noxor = m_round(s_tmp, 4'(r), 2'b00, 2'b00, KEY, 128'h0);
            s_tmp = m_round(s_tmp, 4'(r), 2'b00, (r == 11) ? 2'b01 : 2'b00, KEY, 128'h0);
        end
        exp_init = s_tmp;

        // Reset: asynchronous clear before any clock edge.
        permutation_i = init_state;
        key_i         = KEY;
        data_i        = DATA;
        enable_i      = 1'b1;
        input_mode_i  = 1'b1;
        #1 resetb_i = 1'b0;
        #1;
        check("reset_async", permutation_o, '0);
        @(posedge clock_i); #1;
        @(posedge clock_i); #1;
        check("reset_over_enable", permutation_o, '0);
        enable_i = 1'b0;
        resetb_i = 1'b1;
        step(1'b0, 1'b1, 4'd0, 2'b00, 2'b00);
        step(1'b0, 1'b1, 4'd0, 2'b00, 2'b00);
        check("release_hold", permutation_o, '0);

        // Single-round vectors, each loaded from permutation_i.
        for (int i = 0; i < 9; i++) begin
            permutation_i = vecs[i].s_in;
            step(1'b1, 1'b1, vecs[i].r, vecs[i].xb, vecs[i].xe);
            check(vecs[i].name, permutation_o, vecs[i].exp);
        end

        // 12-round initialization with key XOR on the last round.
        data_i        = '0;
        permutation_i = init_state;
        for (int r = 0; r < 12; r++)
            step(1'b1, (r == 0), 4'(r), 2'b00, (r == 11) ? 2'b01 : 2'b00);
        check("init_12", permutation_o, exp_init);
        check64("init_s3_key", permutation_o[3] ^ KEY[127:64], exp_last_noxor[3]);
        check64("init_s4_key", permutation_o[4] ^ KEY[63:0], exp_last_noxor[4]);

        // Hold with a different external state presented.
        permutation_i = mixed;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd3, 2'b11, 2'b11);
        check("hold_3", permutation_o, exp_init);

        // Async reset during round 6, then restart from permutation_i.
        permutation_i = init_state;
        for (int r = 0; r < 6; r++) step(1'b1, (r == 0), 4'(r), 2'b00, 2'b00);
        check("seq_r5", permutation_o, exp_r5);
        enable_i = 1'b1;
        input_mode_i = 1'b0;
        round_i = 4'd6;
        #2 resetb_i = 1'b0;
        #1;
        check("reset_mid_seq", permutation_o, '0);
        @(posedge clock_i); #1;
        check("reset_mid_held", permutation_o, '0);
        resetb_i = 1'b1;
        for (int r = 0; r < 12; r++)
            step(1'b1, (r == 0), 4'(r), 2'b00, (r == 11) ? 2'b01 : 2'b00);
        check("restart_12", permutation_o, exp_init);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_permutation_xor.md
Name: ascon_permutation_xor

Overview:
- One Ascon permutation round (p_C → p_S → p_L) on a registered 320-bit state, with optional XOR injection before and after the round.
- The state is either loaded from an external input or fed back from the register, so a controller iterates rounds one per clock.
- Serves the Ascon-128 AEAD datapath: initialization, associated data, plaintext/ciphertext and finalization phases.

Parameters:
- None. Fixed widths: 5×64-bit state (type_state from ascon_pack, word 0 = S0), 128-bit key, 128-bit data, 4-bit round index.

Ports:
- clock_i  in  1  single clock; state register updates on rising edge.
- resetb_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  state register load enable.
- input_mode_i  in  1  1: round input = permutation_i; 0: round input = registered state.
- permutation_i  in  320 (type_state)  external state S0..S4.
- round_i  in  4  round index r, selects round constant.
- bypass_xor_begin_i  in  2  pre-round XOR controls (1 = XOR active).
- bypass_xor_end_i  in  2  post-round XOR controls (1 = XOR active).
- key_i  in  128  key K.
- data_i  in  128  data block D.
- permutation_o  out  320 (type_state)  registered state.

Behaviour:
- Datapath, all combinational except the final register:
  - mux: input_mode_i selects permutation_i or permutation_o.
  - xor_begin, then p_C, then p_S, then p_L, then xor_end, then the state register.
- xor_begin:
  - bit0 = 1: S0 ^= D[127:64], S1 ^= D[63:0].
  - bit1 = 1: S2 ^= K[127:64], S3 ^= K[63:0].
  - Both bits may be set together; each applies independently.
- p_C:
  - S2[7:0] ^= c, where c = {~r[3:0], r[3:0]}.
  - Gives F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B for r = 0..11.
  - The same formula applies for r = 12..15; no other bits change.
- p_S: 64 parallel 5-bit Ascon S-boxes.
  - Column j input = {S0[j],S1[j],S2[j],S3[j],S4[j]}, S0 is the MSB.
  - Table: 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17.
- p_L (ROR = rotate right):
  - S0 ^= ROR19 ^ ROR28
  - S1 ^= ROR61 ^ ROR39
  - S2 ^= ROR1 ^ ROR6
  - S3 ^= ROR10 ^ ROR17
  - S4 ^= ROR7 ^ ROR41
- xor_end:
  - bit0 = 1: S3 ^= K[127:64], S4 ^= K[63:0].
  - bit1 = 1: S4 ^= 64'h1.
  - Both bits may be set together.
- Register:
  - resetb_i = 0: permutation_o = 0 immediately, independent of the clock.
  - Rising edge with enable_i = 1: loads the xor_end output.
  - enable_i = 0: holds its value.
  - Reset has priority over enable.
- Latency: one round per enabled clock. Result of a round appears on permutation_o after the rising edge.
- 12-round sequence:
  - Cycle 0: input_mode_i = 1, r = 0.
  - Next 11 cycles: input_mode_i = 0, r = 1..11.
  - End-XOR controls are asserted only in the cycle of the last round.
- Control inputs are sampled only through the combinational path; no internal control state.
- Reset mid-sequence clears the state; the controller must restart with input_mode_i = 1.

Test Plan:
- Reset: resetb_i = 0 with nonzero permutation_i → permutation_o = 0 without a clock edge. Release reset with enable_i = 0 → output stays 0.
- Single round:
  - Stimulus: permutation_i = 0, input_mode_i = 1, r = 0, all XORs off, one enabled edge.
  - Required pre-p_L state: S0 = S1 = S3 = 0xF0, S2 = 0xFFFFFFFFFFFFFF0F, S4 = 0.
  - Check permutation_o equals p_L of that state, per the bit-exact model.
- 12-round init:
  - Inputs: S0..S4 = 00001000808C0001, 6CB10AD9CA912F80, 691AED630E81901F, 0C4C36A20853217C, 46487B3E06D9D7A8; K = 691AED630E81901F6CB10AD9CA912F80.
  - Sequence: r = 0..11, bypass_xor_end_i = 01 at r = 11.
  - Required: final state matches the golden model, and S3/S4 include the K XOR.
- Hold: enable_i = 0 for 3 edges after the sequence → permutation_o unchanged.
- XOR paths, one control bit at a time over a zero state:
  - bypass_xor_begin_i = 01 with D, bypass_xor_begin_i = 10 with K, bypass_xor_end_i = 10.
  - Required: each result equals the golden model with only that XOR applied. With end = 10, S4 LSB is flipped relative to the no-XOR result.
- Asynchronous reset asserted at round 6 of a sequence → output 0 at once. Restart from permutation_i reproduces the scenario-3 result.
